// File: rtl/checkpoint_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module : checkpoint_buffer_pkg
// Shared rename-checkpoint types and defaults
// Rev    : 1.0  initial release
// ============================================================================
package checkpoint_buffer_pkg;

  localparam int CKPT_DEPTH     = 4;
  localparam int PREG_COUNT     = 128;
  localparam int CKPT_ROB_TAG_W = 5;
  localparam int CKPT_FL_PTR_W  = 7;

  typedef struct packed {
    logic                      valid;
    logic [31:0]               pc;
    logic [CKPT_ROB_TAG_W-1:0] rob_tag;
    logic [CKPT_FL_PTR_W-1:0]  fl_ptr;
    logic [PREG_COUNT-1:0]     rdy;
  } ckpt_entry_t;

  // Single-snapshot record still used by the older in-order pipeline
  typedef struct packed {
    logic                      valid;
    logic [31:0]               pc;
    logic [CKPT_FL_PTR_W-1:0]  fl_ptr;
    logic [PREG_COUNT-1:0]     rdy;
  } checkpoint;

  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_CORRECT = 2'd1,
    RES_MISPRED = 2'd2
  } ckpt_resolve_e;

endpackage : checkpoint_buffer_pkg
`default_nettype wire

// File: rtl/ckpt_tag_match.sv
`default_nettype none
// ============================================================================
// Module : ckpt_tag_match
// Combinational ROB-tag CAM over valid checkpoint entries (lowest index wins)
// Rev    : 1.0  initial release
// ============================================================================
module ckpt_tag_match #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic [DEPTH-1:0]         i_valid,
  input  logic [DEPTH*TAG_W-1:0]   i_tags,
  input  logic [TAG_W-1:0]         i_tag,
  output logic                     o_hit,
  output logic [$clog2(DEPTH)-1:0] o_idx
);
  import checkpoint_buffer_pkg::*;

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] w_match;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign w_match[i] = i_valid[i] && (i_tags[i*TAG_W +: TAG_W] == i_tag);
  end

  assign o_hit = |w_match;

  always_comb begin
    o_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_match[i]) o_idx = IW'(i);
    end
  end

endmodule : ckpt_tag_match
`default_nettype wire

// File: rtl/checkpoint_buffer.sv
`default_nettype none
// ============================================================================
// Module : checkpoint_buffer
// Circular age-ordered store of branch rename snapshots with wake-up tracking.
// Optional feature macro: CKPT_PERF_EN (saturating performance counters)
// Rev    : 1.0  initial release
// ============================================================================
module checkpoint_buffer #(
  parameter int DEPTH      = 4,
  parameter int PREG_COUNT = 128,
  parameter int ROB_TAG_W  = 5,
  parameter int FL_PTR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [31:0]                alloc_pc,
  input  logic [ROB_TAG_W-1:0]       alloc_rob_tag,
  input  logic [FL_PTR_W-1:0]        alloc_fl_ptr,
  input  logic [PREG_COUNT-1:0]      ready_table_in,
  output logic [$clog2(DEPTH)-1:0]   alloc_id,
  input  logic                       wb_valid,
  input  logic [6:0]                 wb_preg,
  input  logic                       resolve_valid,
  input  logic [ROB_TAG_W-1:0]       resolve_rob_tag,
  input  logic                       resolve_mispredict,
  output logic                       restore_valid,
  output logic [31:0]                restore_pc,
  output logic [FL_PTR_W-1:0]        restore_fl_ptr,
  output logic [PREG_COUNT-1:0]      restore_ready_table,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
`ifdef CKPT_PERF_EN
  ,
  output logic [31:0]                perf_alloc_cnt,
  output logic [31:0]                perf_mispredict_cnt,
  output logic [31:0]                perf_full_stall_cnt
`endif
);
  import checkpoint_buffer_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]            r_head;
  logic [PW:0]            r_tail;
  logic [DEPTH-1:0]       r_valid;
  logic [31:0]            r_pc   [DEPTH];
  logic [ROB_TAG_W-1:0]   r_tag  [DEPTH];
  logic [FL_PTR_W-1:0]    r_flp  [DEPTH];
  logic [PREG_COUNT-1:0]  r_rdy  [DEPTH];

  logic [DEPTH*ROB_TAG_W-1:0] w_tags_flat;
  logic                   w_hit;
  logic [PW-1:0]          w_hit_idx;
  ckpt_resolve_e          w_res;
  logic                   w_mispred;
  logic                   w_correct;
  logic                   w_alloc;
  logic                   w_head_adv;
  logic [PREG_COUNT-1:0]  w_wb_onehot;
  logic [PW-1:0]          w_mp_dist;
  logic [PW:0]            w_mp_tail;
  logic [DEPTH-1:0]       w_wr;
  logic [DEPTH-1:0]       w_kill;
  logic [DEPTH-1:0]       w_clr;
  logic [DEPTH-1:0]       w_valid_nxt;

  assign count       = r_tail - r_head;
  assign empty       = (r_head == r_tail);
  assign full        = (count == (PW+1)'(DEPTH));
  assign alloc_id    = r_tail[PW-1:0];
  assign alloc_ready = !full && !(resolve_valid && resolve_mispredict);
  assign w_alloc     = alloc_valid && alloc_ready;
  assign w_head_adv  = !empty && !r_valid[r_head[PW-1:0]];
  assign w_wb_onehot = wb_valid ? ({{(PREG_COUNT-1){1'b0}}, 1'b1} << wb_preg) : '0;

  ckpt_tag_match #(
    .DEPTH (DEPTH),
    .TAG_W (ROB_TAG_W)
  ) u_tag_match (
    .i_valid (r_valid),
    .i_tags  (w_tags_flat),
    .i_tag   (resolve_rob_tag),
    .o_hit   (w_hit),
    .o_idx   (w_hit_idx)
  );

  always_comb begin
    w_res = RES_NONE;
    if (resolve_valid && w_hit) w_res = resolve_mispredict ? RES_MISPRED : RES_CORRECT;
  end

  assign w_mispred = (w_res == RES_MISPRED);
  assign w_correct = (w_res == RES_CORRECT);

  // Age offset of the mispredicted slot; the rewound tail keeps the head's wrap lineage
  assign w_mp_dist = w_hit_idx - r_head[PW-1:0];
  assign w_mp_tail = r_head + {1'b0, w_mp_dist};

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] w_off;
    assign w_tags_flat[i*ROB_TAG_W +: ROB_TAG_W] = r_tag[i];
    assign w_off     = PW'(i) - r_head[PW-1:0];
    assign w_wr[i]   = w_alloc && (alloc_id == PW'(i));
    assign w_kill[i] = w_mispred && (w_off >= w_mp_dist);
    assign w_clr[i]  = w_correct && (w_hit_idx == PW'(i));

    always_ff @(posedge clk) begin
      if (w_wr[i]) begin
        r_pc[i]  <= alloc_pc;
        r_tag[i] <= alloc_rob_tag;
        r_flp[i] <= alloc_fl_ptr;
        r_rdy[i] <= ready_table_in | w_wb_onehot;
      end else if (r_valid[i]) begin
        r_rdy[i] <= r_rdy[i] | w_wb_onehot;
      end
    end
  end

  always_comb begin
    w_valid_nxt = r_valid;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_kill[i] || w_clr[i]) w_valid_nxt[i] = 1'b0;
      else if (w_wr[i])          w_valid_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_head_adv) r_head <= r_head + 1'b1;
      if (w_mispred)    r_tail <= w_mp_tail;
      else if (w_alloc) r_tail <= r_tail + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      restore_valid       <= 1'b0;
      restore_pc          <= '0;
      restore_fl_ptr      <= '0;
      restore_ready_table <= '1;
    end else begin
      restore_valid <= w_mispred;
      if (w_mispred) begin
        restore_pc          <= r_pc[w_hit_idx];
        restore_fl_ptr      <= r_flp[w_hit_idx];
        restore_ready_table <= r_rdy[w_hit_idx] | w_wb_onehot;
      end
    end
  end

`ifdef CKPT_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_alloc_cnt      <= '0;
      perf_mispredict_cnt <= '0;
      perf_full_stall_cnt <= '0;
    end else begin
      if (w_alloc && (perf_alloc_cnt != '1))
        perf_alloc_cnt <= perf_alloc_cnt + 1'b1;
      if (w_mispred && (perf_mispredict_cnt != '1))
        perf_mispredict_cnt <= perf_mispredict_cnt + 1'b1;
      if (alloc_valid && full && (perf_full_stall_cnt != '1))
        perf_full_stall_cnt <= perf_full_stall_cnt + 1'b1;
    end
  end
`endif

endmodule : checkpoint_buffer
`default_nettype wire

// File: tb/tb_checkpoint_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_checkpoint_buffer
// Directed + random bench for checkpoint_buffer against an age-ordered queue model
// Rev    : 1.0  initial release
// ============================================================================
module tb_checkpoint_buffer;
  localparam int DEPTH = 4;

  logic         clk, rst_n;
  logic         alloc_valid, alloc_ready;
  logic [31:0]  alloc_pc;
  logic [4:0]   alloc_rob_tag;
  logic [6:0]   alloc_fl_ptr;
  logic [127:0] ready_table_in;
  logic [1:0]   alloc_id;
  logic         wb_valid;
  logic [6:0]   wb_preg;
  logic         resolve_valid;
  logic [4:0]   resolve_rob_tag;
  logic         resolve_mispredict;
  logic         restore_valid;
  logic [31:0]  restore_pc;
  logic [6:0]   restore_fl_ptr;
  logic [127:0] restore_ready_table;
  logic         full, empty;
  logic [2:0]   count;
`ifdef CKPT_PERF_EN
  logic [31:0]  perf_alloc_cnt, perf_mispredict_cnt, perf_full_stall_cnt;
`endif

  checkpoint_buffer #(.DEPTH(4), .PREG_COUNT(128), .ROB_TAG_W(5), .FL_PTR_W(7)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .alloc_valid         (alloc_valid),
    .alloc_ready         (alloc_ready),
    .alloc_pc            (alloc_pc),
    .alloc_rob_tag       (alloc_rob_tag),
    .alloc_fl_ptr        (alloc_fl_ptr),
    .ready_table_in      (ready_table_in),
    .alloc_id            (alloc_id),
    .wb_valid            (wb_valid),
    .wb_preg             (wb_preg),
    .resolve_valid       (resolve_valid),
    .resolve_rob_tag     (resolve_rob_tag),
    .resolve_mispredict  (resolve_mispredict),
    .restore_valid       (restore_valid),
    .restore_pc          (restore_pc),
    .restore_fl_ptr      (restore_fl_ptr),
    .restore_ready_table (restore_ready_table),
    .full                (full),
    .empty               (empty),
    .count               (count)
`ifdef CKPT_PERF_EN
    ,
    .perf_alloc_cnt      (perf_alloc_cnt),
    .perf_mispredict_cnt (perf_mispredict_cnt),
    .perf_full_stall_cnt (perf_full_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: live snapshots (holes included) oldest first, plus head slot
  typedef struct {
    bit           v;
    logic [31:0]  pc;
    logic [4:0]   tag;
    logic [6:0]   flp;
    logic [127:0] rdy;
  } ent_t;

  ent_t         q[$];
  int           hs;
  bit           m_rv;
  logic [31:0]  m_rpc;
  logic [6:0]   m_rflp;
  logic [127:0] m_rrdy;
  int           m_alloc, m_mp, m_stall;
  int           checks, errors;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hs = 0; m_rv = 0; m_rpc = '0; m_rflp = '0; m_rrdy = '1;
    m_alloc = 0; m_mp = 0; m_stall = 0;
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_pc = '0; alloc_rob_tag = '0; alloc_fl_ptr = '0;
    ready_table_in = '0; wb_valid = 0; wb_preg = '0;
    resolve_valid = 0; resolve_rob_tag = '0; resolve_mispredict = 0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit tag_live(input logic [4:0] t);
    foreach (q[k]) if (q[k].v && q[k].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive, check combinational outputs, step model, check registered outputs
  task automatic cyc(input bit av, input logic [31:0] pc, input logic [4:0] tag,
                     input logic [6:0] flp, input logic [127:0] rt,
                     input bit wv, input logic [6:0] wp,
                     input bit rv, input logic [4:0] rtag, input bit mp);
    bit           exp_ready, pop;
    int           j;
    logic [127:0] oh;
    ent_t         e;
    alloc_valid = av; alloc_pc = pc; alloc_rob_tag = tag; alloc_fl_ptr = flp;
    ready_table_in = rt; wb_valid = wv; wb_preg = wp;
    resolve_valid = rv; resolve_rob_tag = rtag; resolve_mispredict = mp;
    #1;
    exp_ready = (q.size() < DEPTH) && !(rv && mp);
    chk("alloc_ready", 128'(alloc_ready), 128'(exp_ready));
    chk("alloc_id", 128'(alloc_id), 128'((hs + q.size()) % DEPTH));

    oh  = wv ? (128'(1) << wp) : '0;
    pop = (q.size() > 0) && !q[0].v;
    j   = -1;
    if (rv) begin
      for (int k = 0; k < q.size(); k++)
        if (j < 0 && q[k].v && q[k].tag == rtag) j = k;
    end
    for (int k = 0; k < q.size(); k++) if (q[k].v) q[k].rdy = q[k].rdy | oh;
    if (av && q.size() == DEPTH) m_stall++;
    m_rv = 0;
    if (j >= 0) begin
      if (mp) begin
        m_rv = 1; m_rpc = q[j].pc; m_rflp = q[j].flp; m_rrdy = q[j].rdy;
        m_mp++;
        while (q.size() > j) q.delete(q.size() - 1);
      end else begin
        q[j].v = 0;
      end
    end
    if (av && exp_ready) begin
      e.v = 1; e.pc = pc; e.tag = tag; e.flp = flp; e.rdy = rt | oh;
      q.push_back(e);
      m_alloc++;
    end
    if (pop) begin
      q.delete(0);
      hs = (hs + 1) % DEPTH;
    end

    @(posedge clk);
    #1;
    chk("count", 128'(count), 128'(q.size()));
    chk("empty", 128'(empty), 128'(q.size() == 0));
    chk("full", 128'(full), 128'(q.size() == DEPTH));
    chk("restore_valid", 128'(restore_valid), 128'(m_rv));
    chk("restore_pc", 128'(restore_pc), 128'(m_rpc));
    chk("restore_fl_ptr", 128'(restore_fl_ptr), 128'(m_rflp));
    chk("restore_rdy", restore_ready_table, m_rrdy);
  endtask

  task automatic alloc(input logic [4:0] tag, input logic [31:0] pc, input logic [6:0] flp,
                       input logic [127:0] rt);
    cyc(1, pc, tag, flp, rt, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic [4:0] tag, input bit mp);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, tag, mp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int          slot_b;
    bit          av, wv, rv, mp;
    logic [4:0]  t, rt_tag;
    checks = 0; errors = 0;
    idle_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_alloc_id", 128'(alloc_id), 128'(0));
    chk("rst_alloc_ready", 128'(alloc_ready), 128'(1));
    chk("rst_restore_valid", 128'(restore_valid), 128'(0));
    chk("rst_restore_rdy", restore_ready_table, {128{1'b1}});

    // Fill to capacity; fifth request must be refused
    for (int i = 3; i <= 6; i++) alloc(5'(i), 32'h100 + 32'(i * 4), 7'(i), rnd128());
    chk("fill_full", 128'(full), 128'(1));
    chk("fill_count", 128'(count), 128'(4));
    alloc(5'd7, 32'h200, 7'd7, rnd128());
    chk("fill_reject_count", 128'(count), 128'(4));
    for (int i = 3; i <= 6; i++) resolve(5'(i), 0);
    idle(4);
    chk("drain_empty", 128'(empty), 128'(1));

    // Writeback after allocation must reach the restored ready table
    alloc(5'd3, 32'h0000_1000, 7'h11, '0);
    cyc(0, 0, 0, 0, 0, 1, 7'd40, 0, 0, 0);
    resolve(5'd3, 1);
    chk("mp_restore_valid", 128'(restore_valid), 128'(1));
    chk("mp_rdy_bit40", 128'(restore_ready_table[40]), 128'(1));
    chk("mp_pc", 128'(restore_pc), 128'(32'h0000_1000));
    chk("mp_flp", 128'(restore_fl_ptr), 128'(7'h11));
    chk("mp_empty", 128'(empty), 128'(1));
    idle(1);
    chk("mp_pulse_end", 128'(restore_valid), 128'(0));
    chk("mp_pc_hold", 128'(restore_pc), 128'(32'h0000_1000));

    // Hole in the middle, then head skips it
    alloc(5'd1, 32'h2000, 7'd1, rnd128());
    alloc(5'd2, 32'h2004, 7'd2, rnd128());
    alloc(5'd3, 32'h2008, 7'd3, rnd128());
    resolve(5'd2, 0);
    chk("hole_count", 128'(count), 128'(3));
    resolve(5'd1, 0);
    idle(2);
    chk("hole_skip_count", 128'(count), 128'(1));
    resolve(5'd3, 1);
    idle(1);

    // Wrap tail twice, then mispredict the second-oldest
    for (int n = 0; n < 8; n++) begin
      alloc(5'(8 + n), 32'h3000 + 32'(n), 7'(n), rnd128());
      resolve(5'(8 + n), 0);
    end
    idle(2);
    alloc(5'd20, 32'h4000, 7'd20, rnd128());
    slot_b = (hs + q.size()) % DEPTH;
    alloc(5'd21, 32'h4004, 7'd21, rnd128());
    alloc(5'd22, 32'h4008, 7'd22, rnd128());
    resolve(5'd21, 1);
    chk("wrap_count", 128'(count), 128'(1));
    chk("wrap_tail", 128'(alloc_id), 128'(slot_b));
    chk("wrap_pc", 128'(restore_pc), 128'(32'h4004));
    resolve(5'd22, 1);
    chk("wrap_killed_nohit", 128'(restore_valid), 128'(0));
    resolve(5'd20, 0);
    idle(2);

    // Unknown-tag mispredict with a concurrent allocation request
    alloc(5'd5, 32'h5000, 7'd5, rnd128());
    alloc(5'd6, 32'h5004, 7'd6, rnd128());
    cyc(1, 32'h5008, 5'd7, 7'd7, rnd128(), 0, 0, 1, 5'd9, 1);
    chk("unk_count", 128'(count), 128'(2));
    chk("unk_restore_valid", 128'(restore_valid), 128'(0));
    resolve(5'd5, 0);
    resolve(5'd6, 0);
    idle(2);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      av = ($urandom % 3) != 0;
      wv = $urandom % 2;
      rv = ($urandom % 3) == 0;
      mp = ($urandom % 4) == 0;
      t  = 5'($urandom % 32);
      for (int g = 0; g < 40 && tag_live(t); g++) t = 5'($urandom % 32);
      if (q.size() > 0 && ($urandom % 4) != 0) rt_tag = q[$urandom % q.size()].tag;
      else rt_tag = 5'($urandom % 32);
      cyc(av, $urandom, t, 7'($urandom), rnd128(), wv, 7'($urandom), rv, rt_tag, mp);
    end

`ifdef CKPT_PERF_EN
    chk("perf_alloc", 128'(perf_alloc_cnt), 128'(m_alloc));
    chk("perf_mp", 128'(perf_mispredict_cnt), 128'(m_mp));
    chk("perf_stall", 128'(perf_full_stall_cnt), 128'(m_stall));
`endif

    // Reset asserted during the restore pulse
    idle(6);
    alloc(5'd1, 32'h6000, 7'd1, rnd128());
    alloc(5'd2, 32'h6004, 7'd2, rnd128());
    resolve(5'd1, 1);
    rst_n = 0;
    #1;
    chk("rr_restore_valid", 128'(restore_valid), 128'(0));
    chk("rr_empty", 128'(empty), 128'(1));
    chk("rr_count", 128'(count), 128'(0));
    chk("rr_restore_rdy", restore_ready_table, {128{1'b1}});
    chk("rr_restore_pc", 128'(restore_pc), 128'(0));
`ifdef CKPT_PERF_EN
    chk("rr_perf_alloc", 128'(perf_alloc_cnt), 128'(0));
    chk("rr_perf_mp", 128'(perf_mispredict_cnt), 128'(0));
    chk("rr_perf_stall", 128'(perf_full_stall_cnt), 128'(0));
`endif
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    #1;
    alloc(5'd4, 32'h7000, 7'd4, rnd128());
    resolve(5'd4, 1);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_checkpoint_buffer
`default_nettype wire

// File: doc/checkpoint_buffer.md
# checkpoint_buffer

Parametrised branch-checkpoint store for the out-of-order core. It replaces the single `checkpoint` record with a circular, age-ordered buffer of DEPTH snapshots. Each snapshot holds branch PC, ROB tag, free-list read pointer and the physical-register ready table. Sits beside rename/dispatch: allocates on every dispatched branch, frees on correct resolution, and restores rename state on a mispredict. Live snapshots track writeback wake-ups so a restored ready table is never stale.

## Interface
Parameters:
- DEPTH, 4 — checkpoint entries; power of 2, ≥2
- PREG_COUNT, 128 — physical registers (ready-table width)
- ROB_TAG_W, 5 — ROB tag width
- FL_PTR_W, 7 — free-list pointer width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alloc_valid  in  1  branch requesting a checkpoint
- alloc_ready  out  1  = !full && !(resolve_valid && resolve_mispredict)
- alloc_pc  in  32  branch PC
- alloc_rob_tag  in  ROB_TAG_W  branch ROB tag
- alloc_fl_ptr  in  FL_PTR_W  free-list read pointer at the branch
- ready_table_in  in  PREG_COUNT  live ready table at the branch
- alloc_id  out  log2(DEPTH)  slot written on accept (= tail index)
- wb_valid  in  1  writeback wake-up
- wb_preg  in  7  physical register becoming ready
- resolve_valid  in  1  branch resolved
- resolve_rob_tag  in  ROB_TAG_W  tag of the resolved branch
- resolve_mispredict  in  1  1 = mispredict, 0 = correct
- restore_valid  out  1  one-cycle restore pulse
- restore_pc  out  32  PC of the mispredicted branch
- restore_fl_ptr  out  FL_PTR_W  free-list pointer to rewind to
- restore_ready_table  out  PREG_COUNT  ready table to reinstate
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  log2(DEPTH)+1  occupied slots, including freed-but-not-retired holes

## Operation
- Per-entry state: valid, pc, rob_tag, fl_ptr, rdy[PREG_COUNT].
- Head and tail pointers are log2(DEPTH)+1 bits wide with a wrap bit. full/empty come from pointer compare.
- **Allocate:** when alloc_valid && alloc_ready, write the tail entry, set valid, then tail+1. The stored snapshot is ready_table_in OR (wb_valid ? onehot(wb_preg) : 0).
- **Wake-up:** when wb_valid, set rdy[wb_preg] in every valid entry.
- **Correct resolve:** find the valid entry whose rob_tag matches and clear its valid bit. Head then advances past invalid entries, one entry per cycle, until it reaches a valid entry or the tail.
- **Mispredict:** on the matching valid entry k:
  - clear valid of k and of every entry from k to tail-1 (wrapping);
  - set tail = k;
  - register entry k's pc and fl_ptr, and rdy OR the same-cycle wb one-hot, onto the restore outputs.
- A resolve tag matching no valid entry is ignored: no state change, no restore.
- Simultaneous allocate and mispredict cannot both occur, because alloc_ready is forced low.
- A correct resolve and an allocate in the same cycle are both performed.

## Timing
- Allocate: entry is visible to resolve and wake-up in the cycle after acceptance.
- restore_valid is asserted exactly one cycle after the mispredict cycle and lasts one cycle. Restore data holds until the next restore.
- full, empty, count and alloc_id are combinational from registered pointers. alloc_ready is also combinational on resolve_valid and resolve_mispredict.
- Reset (asynchronous, any time, including mid-restore):
  - head = tail = 0 and all valid = 0;
  - restore_valid = 0, restore_pc = 0, restore_fl_ptr = 0, restore_ready_table = all-ones;
  - full = 0, empty = 1, count = 0, alloc_id = 0, alloc_ready = 1.

## Configuration
- CKPT_PERF_EN defined: adds output ports perf_alloc_cnt, perf_mispredict_cnt and perf_full_stall_cnt, each 32 bits. They count accepted allocations, accepted mispredict restores, and cycles with alloc_valid && full. Counters saturate at all-ones and reset to 0.
- CKPT_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- The shared types package gains:
  - ckpt_entry_t: valid, pc, rob_tag, fl_ptr, rdy;
  - localparams CKPT_DEPTH = 4 and PREG_COUNT = 128.
- The existing `checkpoint` typedef is retained for the older pipeline.
- One sub-module, ckpt_tag_match: a combinational one-hot tag CAM across entries, returning hit and index.

## Test plan
- After reset: alloc 4 branches (tags 3, 4, 5, 6) → full=1, count=4, alloc_ready=0; a 5th alloc_valid is not accepted.
- Alloc tag 3 with ready_table_in=0, then wb_valid with wb_preg=40, then mispredict tag 3 → next cycle restore_valid=1 and restore_ready_table bit 40 = 1, plus pc and fl_ptr as written; empty=1.
- Alloc tags 1, 2, 3, then correct resolve tag 2 → count stays 3. Correct resolve tag 1 → head skips the hole, count=1 within 2 cycles.
- With DEPTH=4, wrap the tail twice using alloc/resolve pairs, then mispredict the second-oldest entry → tail equals its slot, count=1, only the oldest entry remains valid.
- Mispredict of an unknown tag 9 → restore_valid stays 0 and count is unchanged. Mispredict with alloc_valid in the same cycle → alloc_ready=0 and no entry is written.
- Assert rst_n low in the restore-pulse cycle → restore_valid=0 immediately, empty=1; CKPT_PERF_EN counters read 0.
